key_mixer: RTL and testbench
============================

Name: key_mixer

Overview:
- Stage directly downstream of keyBytesToWords in the RC5/RC6 key schedule.
- Consumes the four key words L[0..3] produced by that stage, plus the magic constants P and Q.
- Builds the expanded key table S[0..T-1] with the standard init pass followed by the 3·max(T,C) mixing loop.
- Exposes the finished table through a registered read port, for use by the encrypt/decrypt round datapath.

Parameters:
- W, 32, word width in bits.
- T, 26, number of S-table words (2r+4, r=11).
- C, 4, number of key words L.
- LGW, 5, log2(W); width of the rotate amount.
- AW, 5, S-table address width (ceil(log2(T))).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low: rst=0 at a rising edge resets the block.
- pW  in  W  magic constant P.
- qW  in  W  magic constant Q.
- l0, l1, l2, l3  in  W each  key words L[0]..L[3], connected to keyBytesToWords out0..out3.
- start  in  1  one-cycle request to run the schedule; sampled only in IDLE.
- busy  out  1  high while in INIT or MIX.
- done  out  1  high in DONE; the S table is valid.
- s_addr  in  AW  S-table read address.
- s_data  out  W  registered read data, S[s_addr].

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; busy=0, done=0, s_data=0.
  - Internal A, B, i, j, k cleared to 0.
  - S-table and L-register contents are not cleared.
  - Reset is legal in any state and aborts an in-progress run; the table is then invalid, and done=0 signals that.
- States: IDLE, INIT, MIX, DONE.
- IDLE → INIT: start=1 at edge E0.
  - l0..l3 latched into L[0..3]; pW and qW latched.
  - i=0, busy=1.
- INIT, edges E1..ET (one word per edge):
  - S[0]=P.
  - S[i]=S[i-1]+Q mod 2^W.
  - At ET: state=MIX; A=B=0, i=j=0, k=0.
- MIX, edges ET+1..ET+3·max(T,C), one step per edge:
  - A = S[i] = (S[i]+A+B) <<< 3.
  - B = L[j] = (L[j]+A_new+B) <<< ((A_new+B) mod W), using the low LGW bits as the rotate amount.
  - i=(i+1) mod T, j=(j+1) mod C, k=k+1.
  - A_new is the value written this same step; the whole step completes combinationally within one cycle.
  - All additions are mod 2^W; rotates are left, circular.
  - When the step with k=3·max(T,C)-1 completes, state=DONE, busy=0, done=1.
- Latency with defaults: done observed high after edge E0+104 (26 init + 78 mix).
- DONE:
  - done held high.
  - start=1 re-enters INIT at the next edge: done→0, busy→1, new L/P/Q latched.
- start is ignored while busy=1. No queueing.
- Read port:
  - s_data <= (s_addr<T) ? S[s_addr] : 0, one-cycle latency, active in every state.
  - A read during INIT or MIX returns the current, partially built value.
  - A read and write of the same entry at the same edge returns the old value.
- L input changes after E0 have no effect on the run in progress.

Test Plan:
1. Reset, then start with pW=0xB7E15163, qW=0x9E3779B9, l0..l3=0. Read s_addr=1 right after E2 → s_data=0x5618CB1C. busy=1, done=0.
2. Same run, read s_addr=0 right after E27 (first mix step) → 0xBF0A8B1D. done first goes high exactly 104 cycles after the start edge, and busy falls on that same edge.
3. Full run with key words from keyBytesToWords for key=0xFFFEEEE58684FFF05FFE493853000434, pW=10, qW=5:
   - Read S[0..25] in DONE; all values must match the bench's behavioural RC5 model.
   - s_addr=26..31 → 0.
4. Pulse start at edges E0+10 and E0+60 of a running schedule → both ignored. Final table and done timing identical to scenario 2.
5. Assert rst=0 for one edge mid-MIX (E0+50) → next cycle busy=0, done=0, s_data=0. A fresh start then completes correctly in 104 cycles.
6. In DONE, change l0..l3 and pulse start → done drops the next cycle. A new table matching the model for the new key appears 104 cycles later.

Source files
------------

// File: rtl/key_mixer.sv
`default_nettype none
// ============================================================================
// Module   : key_mixer
// Purpose  : RC5/RC6 key-schedule mixer. It builds the S table from P/Q and
//            mixes it with the key words L, then serves S through a
//            registered read port.
// Revision : 1.0
// ============================================================================
module key_mixer #(
    parameter int W   = 32,
    parameter int T   = 26,
    parameter int C   = 4,
    parameter int LGW = 5,
    parameter int AW  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  pW,
    input  logic [W-1:0]  qW,
    input  logic [W-1:0]  l0,
    input  logic [W-1:0]  l1,
    input  logic [W-1:0]  l2,
    input  logic [W-1:0]  l3,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] s_addr,
    output logic [W-1:0]  s_data
);

    localparam int c_MIX_STEPS = 3 * ((T > C) ? T : C);
    localparam int c_KW        = $clog2(c_MIX_STEPS + 1);
    localparam int c_CW        = (C > 1) ? $clog2(C) : 1;

    localparam logic [AW-1:0]   c_I_LAST = AW'(T - 1);
    localparam logic [c_CW-1:0] c_J_LAST = c_CW'(C - 1);
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_MIX_STEPS - 1);
    localparam logic [AW:0]     c_T_LIM  = (AW + 1)'(T);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_MIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] r);
        logic [2*W-1:0] dbl;
        dbl = {x, x} << r;
        return dbl[2*W-1:W];
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [AW-1:0]   i_q, i_d;
    logic [c_CW-1:0] j_q, j_d;
    logic [c_KW-1:0] k_q, k_d;
    logic [W-1:0]    p_q, p_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    l_q [C];
    logic [W-1:0]    l_d [C];
    logic [W-1:0]    s_q [T];
    logic [W-1:0]    s_d [T];
    logic [W-1:0]    s_data_q, s_data_d;

    logic [W-1:0]    w_init;
    logic [W-1:0]    w_mix_a;
    logic [W-1:0]    w_ab;
    logic [W-1:0]    w_mix_b;

    // During INIT, A carries the previously written word so S[i-1] needs no extra read port.
    assign w_init  = (i_q == '0) ? p_q : (a_q + q_q);
    assign w_mix_a = rotl(s_q[i_q] + a_q + b_q, LGW'(3));
    assign w_ab    = w_mix_a + b_q;
    assign w_mix_b = rotl(l_q[j_q] + w_ab, w_ab[LGW-1:0]);

    assign busy   = (state_q == ST_INIT) || (state_q == ST_MIX);
    assign done   = (state_q == ST_DONE);
    assign s_data = s_data_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        p_d      = p_q;
        q_d      = q_q;
        l_d      = l_q;
        s_d      = s_q;
        s_data_d = ({1'b0, s_addr} < c_T_LIM) ? s_q[s_addr] : '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_INIT;
                    p_d     = pW;
                    q_d     = qW;
                    l_d[0]  = l0;
                    l_d[1]  = l1;
                    l_d[2]  = l2;
                    l_d[3]  = l3;
                    i_d     = '0;
                end
            end
            ST_INIT: begin
                s_d[i_q] = w_init;
                a_d      = w_init;
                if (i_q == c_I_LAST) begin
                    state_d = ST_MIX;
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ST_MIX: begin
                s_d[i_q] = w_mix_a;
                l_d[j_q] = w_mix_b;
                a_d      = w_mix_a;
                b_d      = w_mix_b;
                i_d      = (i_q == c_I_LAST) ? '0 : i_q + 1'b1;
                j_d      = (j_q == c_J_LAST) ? '0 : j_q + 1'b1;
                k_d      = k_q + 1'b1;
                if (k_q == c_K_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            s_data_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            s_data_q <= s_data_d;
        end
    end

    // Table and key storage keep their contents across reset; only updates are blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= s_d;
            l_q <= l_d;
            p_q <= p_d;
            q_q <= q_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_mixer
// Purpose  : Self-checking bench for key_mixer against a behavioural RC5
//            key-schedule model.
// Revision : 1.0
// ============================================================================
module tb_key_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pW, qW, l0, l1, l2, l3;
    logic        busy, done;
    logic [4:0]  s_addr;
    logic [31:0] s_data;

    always #5 clk = ~clk;

    key_mixer dut (
        .clk    (clk),
        .rst    (rst),
        .pW     (pW),
        .qW     (qW),
        .l0     (l0),
        .l1     (l1),
        .l2     (l2),
        .l3     (l3),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .s_addr (s_addr),
        .s_data (s_data)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          edge_n   = 0;
    int          e0       = 0;
    logic [31:0] exp_s [26];
    logic [31:0] kw    [4];
    logic [31:0] sb    [$];
    vec_t        vecs  [32];

    localparam logic [31:0] P_STD = 32'hB7E15163;
    localparam logic [31:0] Q_STD = 32'h9E3779B9;
    localparam logic [127:0] KEY_A = 128'hFFFEEEE58684FFF05FFE493853000434;
    localparam logic [127:0] KEY_B = 128'h0123456789ABCDEF0011223344556677;

    function automatic logic [31:0] rol(input logic [31:0] x, input int r);
        int rr;
        rr = r % 32;
        if (rr == 0) return x;
        return (x << rr) | (x >> (32 - rr));
    endfunction

    // Reference RC5 schedule: init pass then 3*max(T,C) mixing steps.
    task automatic build_model(input logic [31:0] p, input logic [31:0] q,
                               input logic [31:0] m0, input logic [31:0] m1,
                               input logic [31:0] m2, input logic [31:0] m3);
        logic [31:0] lm [4];
        logic [31:0] a, b;
        int ii, jj;
        lm[0] = m0; lm[1] = m1; lm[2] = m2; lm[3] = m3;
        exp_s[0] = p;
        for (int n = 1; n < 26; n++) exp_s[n] = exp_s[n-1] + q;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int n = 0; n < 78; n++) begin
            a = rol(exp_s[ii] + a + b, 3);
            exp_s[ii] = a;
            b = rol(lm[jj] + a + b, int'((a + b) & 32'd31));
            lm[jj] = b;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 4;
        end
    endtask

    // Little-endian packing of key bytes, first written byte = byte 0.
    task automatic key_words(input logic [127:0] key);
        logic [7:0] kb [16];
        for (int n = 0; n < 16; n++) kb[n] = key[127 - 8*n -: 8];
        for (int n = 0; n < 4; n++) kw[n] = {kb[4*n+3], kb[4*n+2], kb[4*n+1], kb[4*n]};
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic read_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] want;
        s_addr = addr;
        sb.push_back(exp);
        tick();
        want = sb.pop_front();
        check(name, s_data, want);
    endtask

    task automatic do_start(input logic [31:0] p, input logic [31:0] q);
        pW = p; qW = q;
        l0 = kw[0]; l1 = kw[1]; l2 = kw[2]; l3 = kw[3];
        start = 1'b1;
        tick();
        e0 = edge_n;
        start = 1'b0;
    endtask

    task automatic advance_to(input int e);
        while (edge_n - e0 < e) tick();
    endtask

    task automatic wait_done();
        int   guard;
        logic busy_ok;
        guard = 0;
        busy_ok = 1'b1;
        while (!done && guard < 300) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            guard++;
        end
        check("done_latency", 32'(edge_n - e0), 32'd104);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("busy_during_run", {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic check_table(input string name);
        for (int a = 0; a < 32; a++) begin
            vecs[a].addr = 5'(a);
            vecs[a].exp  = (a < 26) ? exp_s[a] : 32'd0;
        end
        for (int a = 0; a < 32; a++) read_check(name, vecs[a].addr, vecs[a].exp);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; s_addr = '0;
        pW = '0; qW = '0; l0 = '0; l1 = '0; l2 = '0; l3 = '0;
        tick(); tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sdata", s_data, 32'd0);
        rst = 1'b1;
        tick();

        // Scenarios 1-2: standard constants, all-zero key.
        kw[0] = 0; kw[1] = 0; kw[2] = 0; kw[3] = 0;
        build_model(P_STD, Q_STD, 0, 0, 0, 0);
        do_start(P_STD, Q_STD);
        advance_to(2);
        read_check("init_s1", 5'd1, 32'h5618CB1C);
        check("init_busy", {31'd0, busy}, 32'd1);
        check("init_done", {31'd0, done}, 32'd0);
        advance_to(27);
        read_check("mix1_s0", 5'd0, 32'hBF0A8B1D);
        wait_done();
        check_table("zero_key_table");

        // Scenario 3: real key, small constants.
        key_words(KEY_A);
        build_model(32'd10, 32'd5, kw[0], kw[1], kw[2], kw[3]);
        do_start(32'd10, 32'd5);
        wait_done();
        check_table("keyA_table");

        // Scenario 4: start pulses during a run are ignored.
        kw[0] = 0; kw[1] = 0; kw[2] = 0; kw[3] = 0;
        build_model(P_STD, Q_STD, 0, 0, 0, 0);
        do_start(P_STD, Q_STD);
        advance_to(9);
        start = 1'b1; tick(); start = 1'b0;
        advance_to(59);
        start = 1'b1; tick(); start = 1'b0;
        wait_done();
        check_table("ignored_start_table");

        // Scenario 5: reset mid-MIX aborts, then a fresh run.
        key_words(KEY_A);
        build_model(32'd10, 32'd5, kw[0], kw[1], kw[2], kw[3]);
        s_addr = 5'd3;
        do_start(32'd10, 32'd5);
        advance_to(49);
        rst = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sdata", s_data, 32'd0);
        rst = 1'b1;
        tick();
        do_start(32'd10, 32'd5);
        wait_done();
        check_table("after_abort_table");

        // Scenario 6: restart from DONE with a new key.
        key_words(KEY_B);
        build_model(P_STD, Q_STD, kw[0], kw[1], kw[2], kw[3]);
        do_start(P_STD, Q_STD);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        l0 = 32'hDEADBEEF; l1 = 32'h12345678;
        wait_done();
        check_table("keyB_table");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
